// File: rtl/clkscale_ctrl_if.sv
// Button inputs and clkscale result bundle between the rate selector and its driver.
interface clkscale_ctrl_if;
  logic        btn_faster;
  logic        btn_slower;
  logic        btn_preset;
  logic [31:0] clkscale;
  logic        changed;
  logic        at_min;
  logic        at_max;

  modport master (
    output btn_faster, btn_slower, btn_preset,
    input  clkscale, changed, at_min, at_max
  );

  modport slave (
    input  btn_faster, btn_slower, btn_preset,
    output clkscale, changed, at_min, at_max
  );
endinterface

// File: rtl/clkscale_ctrl.sv
// Button-driven clkscale selector: sync + debounce three buttons, halve/double/preset
// the divider scale word with auto-repeat and saturation at programmable limits.
module clkscale_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned SCALE_MIN       = 1,
  parameter int unsigned SCALE_MAX       = 25000000,
  parameter int unsigned SCALE_RESET     = 25000000
) (
  input  logic           CCLK,
  input  logic           rst_n,
  clkscale_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_e;

  // Button vector order: bit 0 faster, bit 1 slower, bit 2 preset.
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    rise_q, rise_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  state_e      state_q, state_d;
  logic        dir_q, dir_d;      // 1 = faster is the held direction
  logic [31:0] timer_q, timer_d;
  logic [31:0] clkscale_q, clkscale_d;
  logic        changed_q, changed_d;

  logic        act_preset, act_step, step_fast, load_timer;
  logic [31:0] load_val;
  logic        held, other_rise;
  logic [31:0] halved;
  logic [32:0] doubled;

  assign raw = {bus.btn_preset, bus.btn_slower, bus.btn_faster};

  always_comb begin
    deb_d  = deb_q;
    rise_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) begin
          deb_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CCLK) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      rise_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge CCLK) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      timer_q    <= '0;
      clkscale_q <= SCALE_RESET;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      timer_q    <= timer_d;
      clkscale_q <= clkscale_d;
      changed_q  <= changed_d;
    end
  end

  assign held       = dir_q ? deb_q[0]  : deb_q[1];
  assign other_rise = dir_q ? rise_q[1] : rise_q[0];

  // Transition decode also yields the action to take on this edge.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    act_preset = 1'b0;
    act_step   = 1'b0;
    step_fast  = dir_q;
    load_timer = 1'b0;
    load_val   = REPEAT_RATE;
    unique case (state_q)
      IDLE: begin
        if (rise_q[2]) begin
          act_preset = 1'b1;
          state_d    = LOCK;
        end else if (deb_q[0] && deb_q[1]) begin
          state_d = LOCK;
        end else if (rise_q[0] || rise_q[1]) begin
          act_step   = 1'b1;
          step_fast  = rise_q[0];
          dir_d      = rise_q[0];
          load_timer = 1'b1;
          load_val   = REPEAT_DELAY;
          state_d    = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (rise_q[2]) begin
          act_preset = 1'b1;
          state_d    = LOCK;
        end else if (other_rise) begin
          state_d = LOCK;
        end else if (!held) begin
          state_d = IDLE;
        end else if (timer_q == 32'd1) begin
          act_step   = 1'b1;
          load_timer = 1'b1;
          state_d    = REPEAT;
        end
      end
      LOCK: begin
        if (deb_q == '0) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    halved     = clkscale_q >> 1;
    doubled    = {1'b0, clkscale_q} << 1;
    clkscale_d = clkscale_q;
    if (act_preset) begin
      clkscale_d = SCALE_RESET;
    end else if (act_step) begin
      if (step_fast) clkscale_d = (halved < SCALE_MIN) ? SCALE_MIN : halved;
      else           clkscale_d = (doubled > 33'(SCALE_MAX)) ? SCALE_MAX : doubled[31:0];
    end
    if (load_timer)           timer_d = load_val;
    else if (timer_q != '0)   timer_d = timer_q - 32'd1;
    else                      timer_d = '0;
    changed_d = (clkscale_d != clkscale_q);
  end

  assign bus.clkscale = clkscale_q;
  assign bus.changed  = changed_q;
  assign bus.at_min   = (clkscale_q == SCALE_MIN);
  assign bus.at_max   = (clkscale_q == SCALE_MAX);
endmodule

// File: tb/tb_clkscale_ctrl.sv
// Directed bench for clkscale_ctrl with a cycle-level behavioural model compared every cycle.
module tb_clkscale_ctrl;
  localparam int unsigned D    = 4;
  localparam int unsigned RD   = 20;
  localparam int unsigned RR   = 8;
  localparam int unsigned SMIN = 2;
  localparam int unsigned SMAX = 64;
  localparam int unsigned SRST = 16;

  logic clk = 1'b0;
  logic rst_n;

  clkscale_ctrl_if bus();

  clkscale_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .SCALE_MIN(SMIN),
    .SCALE_MAX(SMAX),
    .SCALE_RESET(SRST)
  ) dut (
    .CCLK(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: mode 0 idle, 1 holding a direction, 2 locked out.
  longint      cyc = 0;
  longint      m_scale = 0;
  bit          m_changed = 0;
  bit          m_valid = 0;
  int          m_mode = 0;
  int          m_dir = 0;        // 0 faster, 1 slower
  longint      m_next = 0;       // absolute edge number of next auto-repeat step
  bit          m_deb [3];
  bit          m_rise [3];
  logic [15:0] hist [3];         // bit k = raw sample k edges ago
  int unsigned nvalid [3];

  function automatic longint stepped(input longint s, input int dir);
    longint r;
    if (dir == 0) begin
      r = s / 2;
      if (r < SMIN) r = SMIN;
    end else begin
      r = s * 2;
      if (r > SMAX) r = SMAX;
    end
    return r;
  endfunction

  task automatic model_edge();
    bit     raw [3];
    longint old;
    bit     all_diff;
    cyc++;
    raw[0] = bus.btn_faster;
    raw[1] = bus.btn_slower;
    raw[2] = bus.btn_preset;
    if (!rst_n) begin
      m_scale   = SRST;
      m_changed = 0;
      m_mode    = 0;
      m_valid   = 1;
      for (int b = 0; b < 3; b++) begin
        m_deb[b]  = 0;
        m_rise[b] = 0;
        hist[b]   = '0;
        nvalid[b] = 1;
      end
    end else begin
      old = m_scale;
      case (m_mode)
        0: begin
          if (m_rise[2]) begin
            m_scale = SRST; m_mode = 2;
          end else if (m_deb[0] && m_deb[1]) begin
            m_mode = 2;
          end else if (m_rise[0] || m_rise[1]) begin
            m_dir   = m_rise[0] ? 0 : 1;
            m_scale = stepped(m_scale, m_dir);
            m_next  = cyc + RD;
            m_mode  = 1;
          end
        end
        1: begin
          if (m_rise[2]) begin
            m_scale = SRST; m_mode = 2;
          end else if (m_rise[1 - m_dir]) begin
            m_mode = 2;
          end else if (!m_deb[m_dir]) begin
            m_mode = 0;
          end else if (cyc == m_next) begin
            m_scale = stepped(m_scale, m_dir);
            m_next  = cyc + RR;
          end
        end
        default: begin
          if (!m_deb[0] && !m_deb[1] && !m_deb[2]) m_mode = 0;
        end
      endcase
      m_changed = (m_scale != old);
      // A level is accepted once D+1 consecutive samples, seen two edges late, all disagree.
      for (int b = 0; b < 3; b++) begin
        hist[b] = {hist[b][14:0], raw[b]};
        if (nvalid[b] < 64) nvalid[b]++;
        m_rise[b] = 0;
        if (nvalid[b] >= D + 3) begin
          all_diff = 1;
          for (int k = 2; k <= int'(D) + 2; k++)
            if (hist[b][k] == m_deb[b]) all_diff = 0;
          if (all_diff) begin
            m_deb[b]  = !m_deb[b];
            m_rise[b] = m_deb[b];
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("clkscale", longint'(bus.clkscale), m_scale);
      check("changed", longint'(bus.changed), longint'(m_changed));
      check("at_min", longint'(bus.at_min), longint'(m_scale == SMIN));
      check("at_max", longint'(bus.at_max), longint'(m_scale == SMAX));
      if (bus.changed === 1'b1) pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
    tick(2);
  endtask

  int p0;

  initial begin
    rst_n = 1'b0;
    bus.btn_faster = 1'b0;
    bus.btn_slower = 1'b0;
    bus.btn_preset = 1'b0;

    // Reset state
    tick(3);
    check("rst_clkscale", longint'(bus.clkscale), 16);
    check("rst_changed", longint'(bus.changed), 0);
    check("rst_at_min", longint'(bus.at_min), 0);
    check("rst_at_max", longint'(bus.at_max), 0);
    rst_n = 1'b1;
    tick(2);

    // Single clean faster press
    p0 = pulses;
    bus.btn_faster = 1'b1;
    tick(7);
    check("fast_before_step", longint'(bus.clkscale), 16);
    tick(1);
    check("fast_step", longint'(bus.clkscale), 8);
    tick(4);
    bus.btn_faster = 1'b0;
    tick(30);
    check("fast_norepeat", longint'(bus.clkscale), 8);
    check("fast_pulses", longint'(pulses - p0), 1);

    // Bouncing button never accepted
    do_reset(3);
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      bus.btn_faster = ~bus.btn_faster;
      tick(2);
    end
    bus.btn_faster = 1'b0;
    tick(20);
    check("bounce_scale", longint'(bus.clkscale), 16);
    check("bounce_pulses", longint'(pulses - p0), 0);

    // Slower held: step, one repeat to the max, then saturate
    p0 = pulses;
    bus.btn_slower = 1'b1;
    tick(8);
    check("slow_step1", longint'(bus.clkscale), 32);
    tick(20);
    check("slow_step2", longint'(bus.clkscale), 64);
    check("slow_at_max", longint'(bus.at_max), 1);
    tick(72);
    check("slow_sat", longint'(bus.clkscale), 64);
    bus.btn_slower = 1'b0;
    tick(20);
    check("slow_pulses", longint'(pulses - p0), 2);

    // Faster, preset, then faster+slower lockout
    do_reset(3);
    bus.btn_faster = 1'b1;
    tick(10);
    check("p5_fast", longint'(bus.clkscale), 8);
    bus.btn_faster = 1'b0;
    tick(20);
    p0 = pulses;
    bus.btn_preset = 1'b1;
    tick(8);
    check("p5_preset", longint'(bus.clkscale), 16);
    tick(4);
    bus.btn_preset = 1'b0;
    tick(20);
    check("p5_preset_pulses", longint'(pulses - p0), 1);
    p0 = pulses;
    bus.btn_faster = 1'b1;
    bus.btn_slower = 1'b1;
    tick(40);
    bus.btn_faster = 1'b0;
    tick(20);
    check("p5_lock_held", longint'(bus.clkscale), 16);
    bus.btn_slower = 1'b0;
    tick(20);
    check("p5_lock_scale", longint'(bus.clkscale), 16);
    check("p5_lock_pulses", longint'(pulses - p0), 0);
    bus.btn_faster = 1'b1;
    tick(8);
    check("p5_unlock_step", longint'(bus.clkscale), 8);
    bus.btn_faster = 1'b0;
    tick(20);

    // Repeat down to the min, then reset mid-repeat with faster still held
    do_reset(3);
    bus.btn_faster = 1'b1;
    tick(8);
    check("p6_step1", longint'(bus.clkscale), 8);
    tick(20);
    check("p6_step2", longint'(bus.clkscale), 4);
    tick(8);
    check("p6_step3", longint'(bus.clkscale), 2);
    check("p6_at_min", longint'(bus.at_min), 1);
    tick(8);
    check("p6_sat", longint'(bus.clkscale), 2);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("p6_reset", longint'(bus.clkscale), 16);
    rst_n = 1'b1;
    tick(7);
    check("p6_redetect_wait", longint'(bus.clkscale), 16);
    tick(1);
    check("p6_redetect", longint'(bus.clkscale), 8);
    bus.btn_faster = 1'b0;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
